// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter; start, data LSB first, optional parity, stop.
// Each bit is held for Prescale clocks, and TX_OUT/busy are registered.
module uart_tx_frame #(
    parameter int data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [data_width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);
    localparam int BW = (data_width > 1) ? $clog2(data_width) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(data_width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [5:0]            edge_cnt_q, edge_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [data_width-1:0] data_q, data_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic [5:0]            presc_q, presc_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [5:0]            last_cnt;
    logic                  last;

    assign last_cnt = (presc_q == 6'd0) ? 6'd0 : presc_q - 6'd1;
    assign last     = edge_cnt_q == last_cnt;
    assign TX_OUT   = tx_q;
    assign busy     = busy_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            presc_q    <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            presc_q    <= presc_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = (state_q == IDLE || last) ? 6'd0 : edge_cnt_q + 6'd1;
        bit_cnt_d  = bit_cnt_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        presc_d    = presc_q;
        case (state_q)
            IDLE: if (Data_Valid) begin
                state_d  = START;
                data_d   = P_DATA;
                par_en_d = PAR_EN;
                par_d    = ^P_DATA ^ PAR_TYP;
                presc_d  = Prescale;
            end
            START: if (last) begin
                state_d   = DATA;
                bit_cnt_d = '0;
            end
            DATA: if (last) begin
                state_d   = (bit_cnt_q != BIT_LAST) ? DATA : (par_en_q ? PARITY : STOP);
                bit_cnt_d = (bit_cnt_q != BIT_LAST) ? bit_cnt_q + 1'b1 : bit_cnt_q;
            end
            PARITY: if (last) state_d = STOP;
            STOP:   if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so the registered line moves with the FSM.
    always_comb begin
        tx_d   = (state_d == START)  ? 1'b0 :
                 (state_d == DATA)   ? data_d[bit_cnt_d] :
                 (state_d == PARITY) ? par_d : 1'b1;
        busy_d = state_d != IDLE;
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed frame vectors plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_frame;
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] P_DATA = '0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd1;
    logic       TX_OUT;
    logic       busy;
    int         checks = 0;
    int         errors = 0;

    uart_tx_frame #(.data_width(8)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Prescale(Prescale),
        .TX_OUT(TX_OUT), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // bits[k] is the k-th transmitted bit (start first); pe is cycles per bit.
    typedef struct {
        string       nm;
        logic [5:0]  p;
        int          pe;
        logic        en;
        logic        typ;
        logic [7:0]  d;
        logic [10:0] bits;
        int          nbits;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_frame(input string nm, input logic [10:0] bits, input int nbits,
                             input int pe, input bit poke);
        int c = 0;
        for (int k = 0; k < nbits; k++) begin
            for (int j = 0; j < pe; j++) begin
                check({nm, " tx"}, 32'(TX_OUT), 32'(bits[k]));
                check({nm, " busy"}, 32'(busy), 32'd1);
                if (poke && c == 0) begin
                    P_DATA   = ~P_DATA;
                    Prescale = 6'd5;
                    PAR_EN   = ~PAR_EN;
                    PAR_TYP  = ~PAR_TYP;
                end
                if (poke && c == 3) Data_Valid = 1'b1;
                if (poke && c == 4) Data_Valid = 1'b0;
                c++;
                tick();
            end
        end
        check({nm, " end busy"}, 32'(busy), 32'd0);
        check({nm, " end tx"}, 32'(TX_OUT), 32'd1);
    endtask

    initial begin
        vecs[0] = '{"a5_even",  6'd8,  8,  1'b1, 1'b0, 8'hA5, 11'b10101001010, 11};
        vecs[1] = '{"01_odd",   6'd8,  8,  1'b1, 1'b1, 8'h01, 11'b10000000010, 11};
        vecs[2] = '{"01_even",  6'd8,  8,  1'b1, 1'b0, 8'h01, 11'b11000000010, 11};
        vecs[3] = '{"ff_nopar", 6'd16, 16, 1'b0, 1'b0, 8'hFF, 11'b01111111110, 10};
        vecs[4] = '{"p0_3c",    6'd0,  1,  1'b0, 1'b0, 8'h3C, 11'b01001111000, 10};
        vecs[5] = '{"a5_odd",   6'd3,  3,  1'b1, 1'b1, 8'hA5, 11'b11101001010, 11};

        tick();
        tick();
        check("reset tx", 32'(TX_OUT), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        RST = 1'b0;
        tick();
        check("idle tx", 32'(TX_OUT), 32'd1);

        foreach (vecs[i]) begin
            P_DATA = vecs[i].d; PAR_EN = vecs[i].en; PAR_TYP = vecs[i].typ;
            Prescale = vecs[i].p; Data_Valid = 1'b1;
            tick();
            Data_Valid = 1'b0;
            run_frame(vecs[i].nm, vecs[i].bits, vecs[i].nbits, vecs[i].pe, 1'b1);
            tick();
            check({vecs[i].nm, " pulse lost"}, 32'(busy), 32'd0);
        end

        // Data_Valid held high: two frames with exactly one idle-high cycle between them
        P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
        tick();
        P_DATA = 8'hAA;
        run_frame("b2b_55", 11'b01010101010, 10, 4, 1'b0);
        tick();
        Data_Valid = 1'b0;
        run_frame("b2b_aa", 11'b01101010100, 10, 4, 1'b0);
        tick();
        check("b2b after", 32'(busy), 32'd0);

        // reset during data bit 3 of 0xA5 (bit value 0), then a clean frame
        P_DATA = 8'hA5; PAR_EN = 1'b0; Prescale = 6'd4; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        check("pre-rst tx", 32'(TX_OUT), 32'd0);
        check("pre-rst busy", 32'(busy), 32'd1);
        RST = 1'b1;
        tick();
        check("mid rst tx", 32'(TX_OUT), 32'd1);
        check("mid rst busy", 32'(busy), 32'd0);
        RST = 1'b0;
        tick();
        P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Prescale = 6'd2; Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        run_frame("post_rst", 11'b10001111000, 11, 2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
